axi_rd_arbiter: RTL and testbench

//  Shares the single AXI read-address/read-data channel between the IF-stage instruction

---
 rtl/axi_rd_arbiter_pkg.sv | 19 +
 rtl/rd_os_counter.sv | 36 +++
 rtl/axi_rd_arbiter.sv | 148 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter: AXI IDs, default outstanding depth,
// arbiter FSM encoding and the outstanding-counter width helper.
package axi_rd_arbiter_pkg;

    localparam logic [3:0] AXI_ID_INST = 4'd0;
    localparam logic [3:0] AXI_ID_DATA = 4'd1;
    localparam int         OS_MAX_DEF  = 2;
    localparam logic [2:0] ARSIZE_WORD = 3'd2;

    typedef enum logic {
        ST_IDLE,
        ST_AR
    } arb_state_t;

    function automatic int os_cnt_width(input int os_max);
        return $clog2(os_max + 1);
    endfunction

endpackage

// File: rtl/rd_os_counter.sv
// Outstanding-read counter for one AXI ID; a full counter blocks further grants,
// so it never wraps upward, and a decrement at zero is reported instead of applied.
module rd_os_counter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int OS_MAX = OS_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty,
    output logic underflow
);

    localparam int            CW      = os_cnt_width(OS_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(OS_MAX);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && count != CNT_MAX) begin
            count <= count + CW'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign full      = (count == CNT_MAX);
    assign empty     = (count == '0);
    assign underflow = dec & empty;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel between the IF instruction fetch and the EXE load path:
// fixed priority (data first), one AR beat in flight, per-ID outstanding limit, RAW stall.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int OS_MAX = OS_MAX_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              inst_rd_req,
    input  logic [ADDR_W-1:0] inst_rd_addr,
    output logic              inst_rd_addr_ok,
    output logic              inst_rd_data_ok,
    input  logic              data_rd_req,
    input  logic [ADDR_W-1:0] data_rd_addr,
    input  logic [1:0]        data_rd_size,
    output logic              data_rd_addr_ok,
    output logic              data_rd_data_ok,
    output logic [31:0]       rd_rdata,
    input  logic              wr_pending,
    input  logic [ADDR_W-1:0] wr_pending_addr,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              err_rid
);

    arb_state_t state;

    logic inst_full;
    logic data_full;
    logic inst_hazard;
    logic data_hazard;
    logic inst_elig;
    logic data_elig;
    logic grant_inst;
    logic grant_data;
    logic r_hs;
    logic inst_dec;
    logic data_dec;
    logic inst_under;
    logic data_under;
    logic rid_unknown;
    logic [1:0] unused_empty;
    logic unused_addr_lsb;

    // A load to the same word as the un-responded write must wait for that write.
    assign inst_hazard = wr_pending &
                         (wr_pending_addr[ADDR_W-1:2] == inst_rd_addr[ADDR_W-1:2]);
    assign data_hazard = wr_pending &
                         (wr_pending_addr[ADDR_W-1:2] == data_rd_addr[ADDR_W-1:2]);
    assign unused_addr_lsb = ^wr_pending_addr[1:0];

    assign inst_elig = inst_rd_req & ~inst_full & ~inst_hazard;
    assign data_elig = data_rd_req & ~data_full & ~data_hazard;

    // rready is low only until the first clock after reset, which also masks grants then.
    assign grant_data = (state == ST_IDLE) & rready & data_elig;
    assign grant_inst = (state == ST_IDLE) & rready & inst_elig & ~data_elig;

    assign inst_rd_addr_ok = grant_inst;
    assign data_rd_addr_ok = grant_data;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            arvalid <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arsize  <= '0;
            rready  <= 1'b0;
        end else begin
            rready <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (grant_data) begin
                        arid    <= AXI_ID_DATA;
                        araddr  <= data_rd_addr;
                        arsize  <= {1'b0, data_rd_size};
                        arvalid <= 1'b1;
                        state   <= ST_AR;
                    end else if (grant_inst) begin
                        arid    <= AXI_ID_INST;
                        araddr  <= inst_rd_addr;
                        arsize  <= ARSIZE_WORD;
                        arvalid <= 1'b1;
                        state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    arvalid <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign r_hs            = rvalid & rready;
    assign rd_rdata        = rdata;
    assign inst_rd_data_ok = r_hs & (rid == AXI_ID_INST);
    assign data_rd_data_ok = r_hs & (rid == AXI_ID_DATA);
    assign inst_dec        = inst_rd_data_ok & rlast;
    assign data_dec        = data_rd_data_ok & rlast;
    assign rid_unknown     = r_hs & (rid != AXI_ID_INST) & (rid != AXI_ID_DATA);

    rd_os_counter #(.OS_MAX(OS_MAX)) u_inst_os (
        .clk       (aclk),
        .rst_n     (aresetn),
        .inc       (grant_inst),
        .dec       (inst_dec),
        .full      (inst_full),
        .empty     (unused_empty[0]),
        .underflow (inst_under)
    );

    rd_os_counter #(.OS_MAX(OS_MAX)) u_data_os (
        .clk       (aclk),
        .rst_n     (aresetn),
        .inc       (grant_data),
        .dec       (data_dec),
        .full      (data_full),
        .empty     (unused_empty[1]),
        .underflow (data_under)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_rid <= 1'b0;
        end else if (rid_unknown || inst_under || data_under) begin
            err_rid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grant order, AR hold, outstanding limit,
// RAW stall, unknown-rid error and asynchronous reset mid-transfer.
module tb_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int OS_MAX = 2;

    logic              aclk;
    logic              aresetn;
    logic              inst_rd_req;
    logic [ADDR_W-1:0] inst_rd_addr;
    logic              inst_rd_addr_ok;
    logic              inst_rd_data_ok;
    logic              data_rd_req;
    logic [ADDR_W-1:0] data_rd_addr;
    logic [1:0]        data_rd_size;
    logic              data_rd_addr_ok;
    logic              data_rd_data_ok;
    logic [31:0]       rd_rdata;
    logic              wr_pending;
    logic [ADDR_W-1:0] wr_pending_addr;
    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arsize;
    logic              arvalid;
    logic              arready;
    logic [3:0]        rid;
    logic [31:0]       rdata;
    logic              rlast;
    logic              rvalid;
    logic              rready;
    logic              err_rid;

    int total = 0;
    int bad   = 0;

    axi_rd_arbiter #(.OS_MAX(OS_MAX), .ADDR_W(ADDR_W)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .inst_rd_req     (inst_rd_req),
        .inst_rd_addr    (inst_rd_addr),
        .inst_rd_addr_ok (inst_rd_addr_ok),
        .inst_rd_data_ok (inst_rd_data_ok),
        .data_rd_req     (data_rd_req),
        .data_rd_addr    (data_rd_addr),
        .data_rd_size    (data_rd_size),
        .data_rd_addr_ok (data_rd_addr_ok),
        .data_rd_data_ok (data_rd_data_ok),
        .rd_rdata        (rd_rdata),
        .wr_pending      (wr_pending),
        .wr_pending_addr (wr_pending_addr),
        .arid            (arid),
        .araddr          (araddr),
        .arsize          (arsize),
        .arvalid         (arvalid),
        .arready         (arready),
        .rid             (rid),
        .rdata           (rdata),
        .rlast           (rlast),
        .rvalid          (rvalid),
        .rready          (rready),
        .err_rid         (err_rid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // One single-beat R response in the current cycle, then advance a cycle.
    task automatic resp(input logic [3:0] id, input logic [31:0] d,
                        input logic exp_inst, input logic exp_data);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        rlast  = 1'b1;
        #2;
        chk("r_inst_data_ok", inst_rd_data_ok, exp_inst);
        chk("r_data_data_ok", data_rd_data_ok, exp_data);
        chk("r_rdata", rd_rdata, d);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn         = 1'b0;
        inst_rd_req     = 1'b1;
        inst_rd_addr    = 32'h0000_0040;
        data_rd_req     = 1'b0;
        data_rd_addr    = '0;
        data_rd_size    = 2'd0;
        wr_pending      = 1'b0;
        wr_pending_addr = '0;
        arready         = 1'b1;
        rid             = 4'd0;
        rdata           = '0;
        rlast           = 1'b0;
        rvalid          = 1'b0;

        // Reset state, with a request already present
        repeat (2) @(posedge aclk);
        #3;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_err_rid", err_rid, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arid", arid, 4'd0);
        chk("rst_arsize", arsize, 3'd0);
        chk("rst_inst_addr_ok", inst_rd_addr_ok, 1'b0);
        inst_rd_req = 1'b0;
        aresetn     = 1'b1;
        tick();

        // Inst only: addr_ok t0, arvalid t1, data_ok t4
        chk("t1_rready_up", rready, 1'b1);
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h0000_0100;
        #2;
        chk("t1_inst_addr_ok", inst_rd_addr_ok, 1'b1);
        chk("t1_data_addr_ok", data_rd_addr_ok, 1'b0);
        tick();
        inst_rd_req = 1'b0;
        #2;
        chk("t1_arvalid", arvalid, 1'b1);
        chk("t1_arid", arid, 4'd0);
        chk("t1_arsize", arsize, 3'd2);
        chk("t1_araddr", araddr, 32'h0000_0100);
        chk("t1_no_ok_in_ar", inst_rd_addr_ok, 1'b0);
        tick();
        chk("t1_ar_done", arvalid, 1'b0);
        tick();
        tick();
        resp(4'd0, 32'h1234_5678, 1'b1, 1'b0);

        // Simultaneous requests: data first, inst two cycles later
        data_rd_req  = 1'b1;
        data_rd_addr = 32'h0000_0200;
        data_rd_size = 2'd1;
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h0000_0300;
        #2;
        chk("t2_data_first", data_rd_addr_ok, 1'b1);
        chk("t2_inst_wait", inst_rd_addr_ok, 1'b0);
        tick();
        data_rd_req = 1'b0;
        #2;
        chk("t2_arvalid", arvalid, 1'b1);
        chk("t2_arid", arid, 4'd1);
        chk("t2_arsize", arsize, 3'd1);
        chk("t2_araddr", araddr, 32'h0000_0200);
        chk("t2_inst_ar", inst_rd_addr_ok, 1'b0);
        tick();
        #2;
        chk("t2_inst_late", inst_rd_addr_ok, 1'b1);
        tick();
        inst_rd_req = 1'b0;
        #2;
        chk("t2_arid_inst", arid, 4'd0);
        chk("t2_araddr_inst", araddr, 32'h0000_0300);
        chk("t2_arsize_inst", arsize, 3'd2);
        tick();
        resp(4'd1, 32'hAAAA_5555, 1'b0, 1'b1);
        resp(4'd0, 32'h5555_AAAA, 1'b1, 1'b0);

        // arready held low: AR stable, no grants
        arready      = 1'b0;
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h0000_0400;
        #2;
        chk("t3_inst_addr_ok", inst_rd_addr_ok, 1'b1);
        tick();
        inst_rd_req  = 1'b0;
        data_rd_req  = 1'b1;
        data_rd_addr = 32'h0000_0500;
        data_rd_size = 2'd2;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("t3_hold_arvalid", arvalid, 1'b1);
            chk("t3_hold_araddr", araddr, 32'h0000_0400);
            chk("t3_hold_data_ok", data_rd_addr_ok, 1'b0);
            tick();
        end
        arready = 1'b1;
        #2;
        chk("t3_hs_arvalid", arvalid, 1'b1);
        chk("t3_hs_data_ok", data_rd_addr_ok, 1'b0);
        tick();
        #2;
        chk("t3_data_after", data_rd_addr_ok, 1'b1);
        tick();
        data_rd_req = 1'b0;
        #2;
        chk("t3_arid", arid, 4'd1);
        chk("t3_araddr", araddr, 32'h0000_0500);
        chk("t3_arsize", arsize, 3'd2);
        tick();
        resp(4'd0, 32'h0000_0400, 1'b1, 1'b0);
        resp(4'd1, 32'h0000_0500, 1'b0, 1'b1);

        // Outstanding limit of 2 on the inst ID
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h0000_0600;
        #2;
        chk("t4_grant1", inst_rd_addr_ok, 1'b1);
        tick();
        tick();
        #2;
        chk("t4_grant2", inst_rd_addr_ok, 1'b1);
        tick();
        tick();
        #2;
        chk("t4_full_block", inst_rd_addr_ok, 1'b0);
        tick();
        #2;
        chk("t4_full_block2", inst_rd_addr_ok, 1'b0);
        resp(4'd0, 32'h0000_0600, 1'b1, 1'b0);
        #2;
        chk("t4_regrant", inst_rd_addr_ok, 1'b1);
        tick();
        inst_rd_req = 1'b0;
        tick();
        resp(4'd0, 32'h0000_0601, 1'b1, 1'b0);
        resp(4'd0, 32'h0000_0602, 1'b1, 1'b0);

        // Read-after-write hazard on the data side
        wr_pending      = 1'b1;
        wr_pending_addr = 32'h0000_1000;
        data_rd_req     = 1'b1;
        data_rd_addr    = 32'h0000_1002;
        data_rd_size    = 2'd2;
        inst_rd_req     = 1'b1;
        inst_rd_addr    = 32'h0000_2000;
        #2;
        chk("t5_data_stall", data_rd_addr_ok, 1'b0);
        chk("t5_inst_pass", inst_rd_addr_ok, 1'b1);
        tick();
        inst_rd_req = 1'b0;
        #2;
        chk("t5_arid_inst", arid, 4'd0);
        chk("t5_araddr_inst", araddr, 32'h0000_2000);
        tick();
        #2;
        chk("t5_still_stalled", data_rd_addr_ok, 1'b0);
        wr_pending = 1'b0;
        #2;
        chk("t5_data_release", data_rd_addr_ok, 1'b1);
        tick();
        data_rd_req = 1'b0;
        #2;
        chk("t5_arid_data", arid, 4'd1);
        chk("t5_araddr_data", araddr, 32'h0000_1002);
        tick();

        // Unknown rid: sticky error, counts untouched (inst=1, data=1)
        rvalid = 1'b1;
        rid    = 4'd5;
        rdata  = 32'hDEAD_BEEF;
        rlast  = 1'b1;
        #2;
        chk("t6_rid5_inst_ok", inst_rd_data_ok, 1'b0);
        chk("t6_rid5_data_ok", data_rd_data_ok, 1'b0);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #2;
        chk("t6_err_set", err_rid, 1'b1);
        tick();
        #2;
        chk("t6_err_sticky", err_rid, 1'b1);
        data_rd_req  = 1'b1;
        data_rd_addr = 32'h0000_0800;
        data_rd_size = 2'd0;
        #2;
        chk("t6_data_grant", data_rd_addr_ok, 1'b1);
        tick();
        data_rd_req = 1'b0;
        #2;
        chk("t6_arsize_byte", arsize, 3'd0);
        tick();
        data_rd_req = 1'b1;
        #2;
        chk("t6_data_full", data_rd_addr_ok, 1'b0);
        data_rd_req  = 1'b0;
        arready      = 1'b0;
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h0000_0700;
        #2;
        chk("t6_inst_grant", inst_rd_addr_ok, 1'b1);
        tick();
        inst_rd_req = 1'b0;
        #2;
        chk("t6_in_ar", arvalid, 1'b1);

        // Asynchronous reset while in AR
        aresetn = 1'b0;
        #1;
        chk("t7_rst_arvalid", arvalid, 1'b0);
        chk("t7_rst_err", err_rid, 1'b0);
        chk("t7_rst_rready", rready, 1'b0);
        chk("t7_rst_araddr", araddr, 32'h0);
        #1;
        aresetn = 1'b1;
        arready = 1'b1;
        tick();
        inst_rd_req  = 1'b1;
        inst_rd_addr = 32'h0000_0900;
        #2;
        chk("t7_post_grant1", inst_rd_addr_ok, 1'b1);
        tick();
        tick();
        #2;
        chk("t7_post_grant2", inst_rd_addr_ok, 1'b1);
        tick();
        tick();
        #2;
        chk("t7_post_full", inst_rd_addr_ok, 1'b0);
        data_rd_req  = 1'b1;
        data_rd_addr = 32'h0000_0A00;
        #2;
        chk("t7_data_cnt_clear", data_rd_addr_ok, 1'b1);
        tick();
        data_rd_req = 1'b0;
        inst_rd_req = 1'b0;
        #2;
        chk("t7_arid_data", arid, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
